// File: rtl/assert_mon_pkg.sv
// Shared types and helpers for the runtime assertion monitor bank.
package assert_mon_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2,
        FAILED  = 2'd3
    } chan_state_e;

    typedef enum logic {
        IMMEDIATE = 1'b0,
        DEFERRED  = 1'b1
    } mode_e;

    localparam int unsigned MAX_CNT_W = 32;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                     input int unsigned width);
        logic [MAX_CNT_W-1:0] max_val;
        max_val = (width >= MAX_CNT_W) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/assert_monitor_bank_if.sv
// Condition, control and readout bundle of the assertion monitor bank.
interface assert_monitor_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TS_W   = 16
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] cond;
    logic [NUM_CH-1:0] qual;
    logic              glb_on;
    logic              glb_off;
    logic              mask_wr;
    logic [NUM_CH-1:0] mask_wdata;
    logic [NUM_CH-1:0] mode_wdata;
    logic              clr;
    logic [SEL_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  rd_pass_cnt;
    logic [CNT_W-1:0]  rd_fail_cnt;
    logic              fail_any;
    logic              first_fail_vld;
    logic [SEL_W-1:0]  first_fail_ch;
    logic [TS_W-1:0]   first_fail_ts;

    modport master (
        output cond, qual, glb_on, glb_off, mask_wr, mask_wdata, mode_wdata, clr, rd_sel,
        input  rd_pass_cnt, rd_fail_cnt, fail_any, first_fail_vld, first_fail_ch, first_fail_ts
    );

    modport slave (
        input  cond, qual, glb_on, glb_off, mask_wr, mask_wdata, mode_wdata, clr, rd_sel,
        output rd_pass_cnt, rd_fail_cnt, fail_any, first_fail_vld, first_fail_ch, first_fail_ts
    );
endinterface

// File: rtl/assert_mon_chan.sv
// One checked condition: immediate/deferred evaluation FSM plus saturating pass/fail counters.
module assert_mon_chan
    import assert_mon_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DEFER_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed,
    input  logic             cond,
    input  mode_e            mode,
    input  logic             cfg_wr,
    input  logic             clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_evt
);
    localparam int unsigned STK_W = $clog2(DEFER_CYC + 1);

    chan_state_e      state_q, state_d;
    logic [STK_W-1:0] streak_q, streak_d;
    logic [CNT_W-1:0] pass_q, fail_q;
    logic             pass_inc, fail_inc;

    // Next state and per-cycle pass/fail events.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        pass_inc = 1'b0;
        fail_inc = 1'b0;
        // A config write drops any partial streak and skips evaluation for that cycle.
        if (cfg_wr || !armed) begin
            state_d  = OFF;
            streak_d = '0;
        end else if (mode == IMMEDIATE) begin
            state_d  = ARMED;
            streak_d = '0;
            pass_inc = cond;
            fail_inc = !cond;
        end else begin
            unique case (state_q)
                OFF, ARMED, FAILED: begin
                    if (cond) begin
                        pass_inc = 1'b1;
                        state_d  = ARMED;
                        streak_d = '0;
                    end else if (state_q != FAILED) begin
                        streak_d = STK_W'(1);
                        if (DEFER_CYC == 1) begin
                            fail_inc = 1'b1;
                            state_d  = FAILED;
                        end else begin
                            state_d  = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (cond) begin
                        pass_inc = 1'b1;
                        state_d  = ARMED;
                        streak_d = '0;
                    end else begin
                        streak_d = streak_q + STK_W'(1);
                        if (streak_d == STK_W'(DEFER_CYC)) begin
                            fail_inc = 1'b1;
                            state_d  = FAILED;
                        end
                    end
                end
            endcase
        end
    end

    // FSM state and streak length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OFF;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Saturating counters; clr discards events of its own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= '0;
            fail_q <= '0;
        end else if (clr) begin
            pass_q <= '0;
            fail_q <= '0;
        end else begin
            if (pass_inc) pass_q <= CNT_W'(sat_inc(MAX_CNT_W'(pass_q), CNT_W));
            if (fail_inc) fail_q <= CNT_W'(sat_inc(MAX_CNT_W'(fail_q), CNT_W));
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign fail_evt = fail_inc;

endmodule

// File: rtl/assert_monitor_bank.sv
// Bank of runtime checkers with global enable, mask/mode config, timestamp and first-fail capture.
module assert_monitor_bank
    import assert_mon_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned DEFER_CYC  = 3,
    parameter bit          GLB_ON_RST = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    assert_monitor_bank_if.slave  bus
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   glb_en_q;
    logic [NUM_CH-1:0]      mask_q, mode_q, armed, fail_vec;
    logic [TS_W-1:0]        ts_q;
    logic                   fail_any_q, ff_vld_q;
    logic [SEL_W-1:0]       ff_ch_q, first_idx;
    logic [TS_W-1:0]        ff_ts_q;
    logic [CNT_W-1:0]       pass_arr [NUM_CH];
    logic [CNT_W-1:0]       fail_arr [NUM_CH];

    assign armed = {NUM_CH{glb_en_q}} & mask_q & bus.qual;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assert_mon_chan #(
            .CNT_W     (CNT_W),
            .DEFER_CYC (DEFER_CYC)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .armed    (armed[i]),
            .cond     (bus.cond[i]),
            .mode     (mode_e'(mode_q[i])),
            .cfg_wr   (bus.mask_wr),
            .clr      (bus.clr),
            .pass_cnt (pass_arr[i]),
            .fail_cnt (fail_arr[i]),
            .fail_evt (fail_vec[i])
        );
    end

    // Global enable (off wins), channel config and free-running timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glb_en_q <= GLB_ON_RST;
            mask_q   <= '1;
            mode_q   <= '0;
            ts_q     <= '0;
        end else begin
            if (bus.glb_off)     glb_en_q <= 1'b0;
            else if (bus.glb_on) glb_en_q <= 1'b1;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_wdata;
                mode_q <= bus.mode_wdata;
            end
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Lowest-index failing channel of this cycle.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fail_vec[i]) first_idx = SEL_W'(i);
        end
    end

    // Sticky fail flag and first-fail capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_any_q <= 1'b0;
            ff_vld_q   <= 1'b0;
            ff_ch_q    <= '0;
            ff_ts_q    <= '0;
        end else if (bus.clr) begin
            fail_any_q <= 1'b0;
            ff_vld_q   <= 1'b0;
            ff_ch_q    <= '0;
            ff_ts_q    <= '0;
        end else if (|fail_vec) begin
            fail_any_q <= 1'b1;
            if (!ff_vld_q) begin
                ff_vld_q <= 1'b1;
                ff_ch_q  <= first_idx;
                ff_ts_q  <= ts_q;
            end
        end
    end

    // Readout mux; out-of-range selects read as zero.
    always_comb begin
        bus.rd_pass_cnt = '0;
        bus.rd_fail_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                bus.rd_pass_cnt = pass_arr[i];
                bus.rd_fail_cnt = fail_arr[i];
            end
        end
    end

    assign bus.fail_any       = fail_any_q;
    assign bus.first_fail_vld = ff_vld_q;
    assign bus.first_fail_ch  = ff_ch_q;
    assign bus.first_fail_ts  = ff_ts_q;

endmodule

// File: tb/tb_assert_monitor_bank.sv
// Directed bench for assert_monitor_bank with immediate-assertion checks.
module tb_assert_monitor_bank;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned TS_W      = 16;
    localparam int unsigned DEFER_CYC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    int   exp_ts  = 0;

    always #5 clk = ~clk;

    assert_monitor_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W)) bus ();

    assert_monitor_bank #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .TS_W       (TS_W),
        .DEFER_CYC  (DEFER_CYC),
        .GLB_ON_RST (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int ch, input int exp_pass, input int exp_fail);
        bus.rd_sel = 2'(ch);
        #1;
        chk({tag, "_pass"}, 32'(bus.rd_pass_cnt), 32'(exp_pass));
        chk({tag, "_fail"}, 32'(bus.rd_fail_cnt), 32'(exp_fail));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        bus.cond       = '0;
        bus.qual       = '1;
        bus.glb_on     = 1'b0;
        bus.glb_off    = 1'b0;
        bus.mask_wr    = 1'b0;
        bus.mask_wdata = '0;
        bus.mode_wdata = '0;
        bus.clr        = 1'b0;
        bus.rd_sel     = '0;

        // 1: checking off after reset, failing conditions are ignored
        do_reset();
        chk("rst_fail_any", 32'(bus.fail_any), 32'd0);
        chk("rst_vld", 32'(bus.first_fail_vld), 32'd0);
        step(10);
        for (int ch = 0; ch < 4; ch++) chk_cnt("t1_off", ch, 0, 0);
        chk("t1_fail_any", 32'(bus.fail_any), 32'd0);

        // 2: immediate ch0 fails at ts 5..7
        do_reset();
        bus.cond   = 4'hF;
        bus.glb_on = 1'b1;
        step(1);
        bus.glb_on = 1'b0;
        step(4);
        bus.cond = 4'hE;
        exp_ts   = edge_n;
        step(3);
        bus.cond = 4'hF;
        chk_cnt("t2_ch0", 0, 4, 3);
        chk("t2_fail_any", 32'(bus.fail_any), 32'd1);
        chk("t2_vld", 32'(bus.first_fail_vld), 32'd1);
        chk("t2_ch", 32'(bus.first_fail_ch), 32'd0);
        chk("t2_ts", 32'(bus.first_fail_ts), 32'(exp_ts));
        chk("t2_ts5", 32'(exp_ts), 32'd5);

        // 3: ch1 deferred, short glitch filtered, long streak reports once
        bus.mask_wdata = 4'hF;
        bus.mode_wdata = 4'b0010;
        bus.mask_wr    = 1'b1;
        bus.clr        = 1'b1;
        step(1);
        bus.mask_wr = 1'b0;
        bus.clr     = 1'b0;
        bus.cond    = 4'b1101;
        step(2);
        bus.cond = 4'hF;
        step(1);
        chk_cnt("t3_glitch", 1, 1, 0);
        bus.cond = 4'b1101;
        step(5);
        bus.cond = 4'hF;
        step(1);
        chk_cnt("t3_streak", 1, 2, 1);
        chk("t3_ch", 32'(bus.first_fail_ch), 32'd1);

        // 4: qual masks ch2; glb_on+glb_off together turns checking off
        bus.clr = 1'b1;
        step(1);
        bus.clr  = 1'b0;
        bus.qual = 4'b1011;
        bus.cond = 4'b1011;
        step(3);
        bus.qual = 4'hF;
        bus.cond = 4'hF;
        step(4);
        chk_cnt("t4_qual", 2, 4, 0);
        bus.glb_on  = 1'b1;
        bus.glb_off = 1'b1;
        step(1);
        bus.glb_on  = 1'b0;
        bus.glb_off = 1'b0;
        bus.cond    = 4'b1011;
        step(3);
        bus.cond = 4'hF;
        chk_cnt("t4_off", 2, 5, 0);
        chk("t4_fail_any", 32'(bus.fail_any), 32'd0);

        // 5: pass counter saturates at 15, clr wipes counters and flags
        bus.glb_on = 1'b1;
        bus.clr    = 1'b1;
        step(1);
        bus.glb_on = 1'b0;
        bus.clr    = 1'b0;
        step(20);
        chk_cnt("t5_sat", 3, 15, 0);
        bus.cond = 4'b0111;
        step(1);
        chk("t5_fail_any", 32'(bus.fail_any), 32'd1);
        bus.cond = 4'hF;
        bus.clr  = 1'b1;
        step(1);
        bus.clr = 1'b0;
        chk_cnt("t5_clr", 3, 0, 0);
        chk("t5_clr_fail_any", 32'(bus.fail_any), 32'd0);
        chk("t5_clr_vld", 32'(bus.first_fail_vld), 32'd0);

        // 6: simultaneous ch0/ch2 failure captures ch0; async reset mid-PENDING
        bus.cond = 4'b1010;
        exp_ts   = edge_n;
        step(1);
        bus.cond = 4'hF;
        chk("t6_vld", 32'(bus.first_fail_vld), 32'd1);
        chk("t6_ch", 32'(bus.first_fail_ch), 32'd0);
        chk("t6_ts", 32'(bus.first_fail_ts), 32'(exp_ts));
        chk_cnt("t6_ch2", 2, 0, 1);
        bus.cond = 4'b1101;
        step(1);
        rst = 1'b1;
        #1;
        chk("t6_rst_fail_any", 32'(bus.fail_any), 32'd0);
        chk("t6_rst_vld", 32'(bus.first_fail_vld), 32'd0);
        chk("t6_rst_ts", 32'(bus.first_fail_ts), 32'd0);
        chk_cnt("t6_rst_ch2", 2, 0, 0);
        bus.cond = 4'hF;
        step(2);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
